// File: rtl/dma_copier.sv
// dma_copier: word-at-a-time memory-to-memory copy engine.
// A transfer moves 'len' 32-bit words from src to dst at two cycles per word.
// Each word takes one READ cycle, where mem_rd is captured, and then one WRITE
// cycle. Either address may be pinned so that the engine can stream from or
// to an MMIO register.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   start                 begin a transfer (looked at only while idle)
//   src, dst, len         first source/destination byte address, word count
//   src_fix, dst_fix      hold the source/destination address constant
//   mem_we/mem_a/mem_wd   data memory write enable, byte address, write data
//   mem_rd                combinational read data for mem_a
//   busy                  high through every READ and WRITE cycle
//   done                  one-cycle completion pulse
//   err                   sticky: the last request was misaligned
//   count                 words written in the current or last transfer
module dma_copier #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             src_fix,
    input  logic             dst_fix,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
    logic             src_fix_q, src_fix_d, dst_fix_q, dst_fix_d, err_q, err_d;
    logic             mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]      mem_a_q, mem_a_d, mem_wd_q, mem_wd_d;

    logic [31:0]      src_nx, dst_nx;
    logic [LEN_W-1:0] cnt_inc;
    logic             misalign;

    // Every output is registered, so each one is computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        src_fix_d = src_fix_q;
        dst_fix_d = dst_fix_q;
        data_d    = data_q;
        count_d   = count_q;
        err_d     = err_q;
        mem_we_d  = 1'b0;
        mem_a_d   = 32'd0;
        mem_wd_d  = 32'd0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        src_nx   = src_fix_q ? src_q : src_q + 32'd4;
        dst_nx   = dst_fix_q ? dst_q : dst_q + 32'd4;
        cnt_inc  = count_q + LEN_W'(1);
        misalign = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d     = src;
                    dst_d     = dst;
                    len_d     = len;
                    src_fix_d = src_fix;
                    dst_fix_d = dst_fix;
                    count_d   = '0;
                    err_d     = misalign;
                    // A rejected or empty request goes straight to the done pulse.
                    if (misalign || (len == '0)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                        mem_a_d = src;
                    end
                end
            end
            READ: begin
                data_d   = mem_rd;
                state_d  = WRITE;
                busy_d   = 1'b1;
                mem_we_d = 1'b1;
                mem_a_d  = dst_q;
                mem_wd_d = mem_rd;
            end
            WRITE: begin
                count_d = cnt_inc;
                src_d   = src_nx;
                dst_d   = dst_nx;
                if (cnt_inc == len_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                    busy_d  = 1'b1;
                    mem_a_d = src_nx;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= '0;
            src_fix_q <= 1'b0;
            dst_fix_q <= 1'b0;
            data_q    <= 32'd0;
            count_q   <= '0;
            err_q     <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= 32'd0;
            mem_wd_q  <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            src_fix_q <= src_fix_d;
            dst_fix_q <= dst_fix_d;
            data_q    <= data_d;
            count_q   <= count_d;
            err_q     <= err_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_wd_q  <= mem_wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign count  = count_q;

endmodule

// File: tb/tb_dma_copier.sv
// tb_dma_copier: directed bench for dma_copier. It provides a 64-word RAM,
// a switch register at C000_0000 and an LED register at C000_0004.
module tb_dma_copier;

    localparam int LEN_W = 7;

    logic             clk, reset, start, src_fix, dst_fix;
    logic [31:0]      src, dst, mem_a, mem_wd, mem_rd;
    logic [LEN_W-1:0] len, count;
    logic             mem_we, busy, done, err;

    logic [31:0] ram [0:63];
    logic [31:0] switches, leds;
    int we_cnt, done_cnt, busy_cnt, sw_rd, led_wr, dbl_we;
    int checks, errors;

    dma_copier #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .src_fix(src_fix), .dst_fix(dst_fix), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .done(done), .err(err),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a == 32'hC000_0000) ? switches : ram[mem_a[7:2]];

    // Memory, LED register and activity counters, all in one process.
    initial begin
        logic we_prev;
        we_prev = 1'b0;
        we_cnt = 0; done_cnt = 0; busy_cnt = 0; sw_rd = 0; led_wr = 0; dbl_we = 0;
        leds = 32'd0;
        for (int i = 0; i < 64; i++) ram[i] = 32'hDEAD_0000 | i;
        ram[0] = 32'd11; ram[1] = 32'd22; ram[2] = 32'd33; ram[3] = 32'd44;
        forever begin
            @(posedge clk);
            if (mem_we) begin
                we_cnt++;
                if (mem_a == 32'hC000_0004) begin
                    leds = mem_wd;
                    led_wr++;
                end else if (mem_a[31:8] == 24'd0) begin
                    ram[mem_a[7:2]] = mem_wd;
                end
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (busy && !mem_we && mem_a == 32'hC000_0000) sw_rd++;
            if (mem_we && we_prev) dbl_we++;
            we_prev = mem_we;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // On return, the start edge has passed and the bench sits just after it.
    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int l,
                        input logic sf, input logic df);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = LEN_W'(l); src_fix = sf; dst_fix = df;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // n counts negedges after the start edge; n=1 is the first cycle after it.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
    endtask

    int n, w0, d0, b0, s0, l0;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; src = 32'd0; dst = 32'd0; len = '0;
        src_fix = 1'b0; dst_fix = 1'b0; switches = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_a", mem_a, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {25'd0, count}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Plain 4-word copy from word 0 to 0x40.
        w0 = we_cnt; d0 = done_cnt;
        kick(32'd0, 32'h40, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_rd_a", mem_a, 32'd0);
        chk("t1_rd_busy", {31'd0, busy}, 32'd1);
        chk("t1_rd_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("t1_wr_we", {31'd0, mem_we}, 32'd1);
        chk("t1_wr_a", mem_a, 32'h40);
        chk("t1_wr_wd", mem_wd, 32'd11);
        wait_done(2, n);
        chk("t1_lat", n, 9);
        @(negedge clk);
        chk("t1_done_1cyc", {31'd0, done}, 32'd0);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        chk("t1_count", {25'd0, count}, 32'd4);
        chk("t1_ram16", ram[16], 32'd11);
        chk("t1_ram17", ram[17], 32'd22);
        chk("t1_ram18", ram[18], 32'd33);
        chk("t1_ram19", ram[19], 32'd44);
        chk("t1_wes", we_cnt - w0, 4);
        chk("t1_dones", done_cnt - d0, 1);

        // MMIO stream: switches to LEDs with both addresses pinned.
        switches = 32'h2A5;
        s0 = sw_rd; l0 = led_wr;
        kick(32'hC000_0000, 32'hC000_0004, 3, 1'b1, 1'b1);
        wait_done(0, n);
        chk("t2_lat", n, 7);
        chk("t2_sw_rd", sw_rd - s0, 3);
        chk("t2_led_wr", led_wr - l0, 3);
        chk("t2_leds", leds, 32'h2A5);
        chk("t2_count", {25'd0, count}, 32'd3);

        // Misaligned source is rejected without touching memory.
        repeat (2) @(negedge clk);
        w0 = we_cnt; b0 = busy_cnt;
        kick(32'h2, 32'h40, 5, 1'b0, 1'b0);
        wait_done(0, n);
        chk("t3_lat", n, 1);
        chk("t3_err", {31'd0, err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", {31'd0, err}, 32'd1);
        chk("t3_wes", we_cnt - w0, 0);
        chk("t3_busy", busy_cnt - b0, 0);

        // Zero-length request: immediate done; the accepted start clears err.
        w0 = we_cnt; b0 = busy_cnt;
        kick(32'd0, 32'h80, 0, 1'b0, 1'b0);
        wait_done(0, n);
        chk("t4_lat", n, 1);
        chk("t4_err", {31'd0, err}, 32'd0);
        chk("t4_count", {25'd0, count}, 32'd0);
        chk("t4_wes", we_cnt - w0, 0);
        chk("t4_busy", busy_cnt - b0, 0);

        // Reset during the third WRITE of an 8-word copy.
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        kick(32'h10, 32'hA0, 8, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) @(negedge clk);
        chk("t5_in_write", {31'd0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
        chk("t5_rst_a", mem_a, 32'd0);
        chk("t5_rst_wd", mem_wd, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_cnt", {25'd0, count}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_resume", {31'd0, busy}, 32'd0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_ram40", ram[40], 32'hDEAD_0004);
        chk("t5_ram41", ram[41], 32'hDEAD_0005);
        chk("t5_ram42", ram[42], 32'hDEAD_002A);
        kick(32'h10, 32'hA0, 8, 1'b0, 1'b0);
        wait_done(0, n);
        chk("t5_lat", n, 17);
        @(negedge clk);
        chk("t5_ram47", ram[47], 32'hDEAD_000B);
        chk("t5_count", {25'd0, count}, 32'd8);

        // A second start while busy must be ignored.
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        kick(32'd0, 32'hC0, 2, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; src = 32'h10; dst = 32'h40; len = LEN_W'(1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(4, n);
        chk("t6_lat", n, 5);
        repeat (4) @(negedge clk);
        chk("t6_dones", done_cnt - d0, 1);
        chk("t6_ram48", ram[48], 32'd11);
        chk("t6_ram49", ram[49], 32'd22);
        chk("t6_ram16", ram[16], 32'd11);
        chk("t6_count", {25'd0, count}, 32'd2);
        chk("t6_idle", {31'd0, busy}, 32'd0);

        chk("no_dbl_we", dbl_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
